mcp3x08_scanner: RTL and testbench

MCP3X08_SCANNER -- requirements
Module: mcp3x08_scanner

---
 rtl/mcp3x08_scanner.sv | 175 +++++++++++++++++
 tb/tb_mcp3x08_scanner.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcp3x08_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mcp3x08_scanner: round-robin SPI mode-0 scanner for MCP3008/MCP3208 ADCs.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mcp3x08_scanner #(
  parameter int         ADC_BITS  = 10,
  parameter int         CHANNELS  = 2,
  parameter int         CLK_DIV   = 32,
  parameter int         CS_IDLE   = 4,
  parameter logic [7:0] DIFF_MASK = 8'h00
) (
  input  logic                         CLK50,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         trigger,
  input  logic                         SPI_IN,
  output logic                         SPI_OUT,
  output logic                         SCLK,
  output logic                         CS_n,
  output logic [CHANNELS*ADC_BITS-1:0] adc_out,
  output logic [CHANNELS-1:0]          adc_valid,
  output logic                         busy,
  output logic                         scan_done
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SHIFT   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  localparam int CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CS_IDLE - 1);
  localparam logic [4:0]       LAST_BIT  = 5'd23;
  localparam logic [4:0]       START_IDX = 5'(17 - ADC_BITS);
  localparam logic [2:0]       LAST_CH   = 3'(CHANNELS - 1);

  logic [1:0]          state_q, state_d;
  logic [2:0]          ch_q, ch_d;
  logic [4:0]          bit_q, bit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [ADC_BITS-1:0] rx_q;
  logic                mosi_q, sclk_q, csn_q;
  logic [CHANNELS*ADC_BITS-1:0] adc_out_q;
  logic [CHANNELS-1:0] adc_valid_q;

  logic w_div_end;
  logic w_rise;
  logic w_load;

  // Command word: start, SGL/DIFF, D2..D0; every other slot is zero.
  function automatic logic frame_bit(input logic [4:0] idx, input logic [2:0] ch);
    logic b;
    b = 1'b0;
    if (idx == START_IDX)              b = 1'b1;
    else if (idx == START_IDX + 5'd1)  b = ~DIFF_MASK[ch];
    else if (idx == START_IDX + 5'd2)  b = ch[2];
    else if (idx == START_IDX + 5'd3)  b = ch[1];
    else if (idx == START_IDX + 5'd4)  b = ch[0];
    return b;
  endfunction

  assign w_div_end = (cnt_q == DIV_LAST);
  assign w_rise    = (state_q == SHIFT) && !phase_q && w_div_end;
  assign w_load    = (state_q == SHIFT) && phase_q && w_div_end && (bit_q == LAST_BIT);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        if (enable || trigger) begin
          state_d = SHIFT;
          ch_d    = 3'd0;
          bit_d   = 5'd0;
          cnt_d   = '0;
          phase_d = 1'b0;
        end
      end
      SHIFT: begin
        if (w_div_end) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
          if (phase_q) begin
            if (bit_q == LAST_BIT) state_d = CAPTURE;
            else                   bit_d   = bit_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        state_d = HOLD;
        cnt_d   = '0;
        bit_d   = 5'd0;
        phase_d = 1'b0;
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          bit_d = 5'd0;
          if (ch_q == LAST_CH) begin
            ch_d    = 3'd0;
            state_d = enable ? SHIFT : IDLE;
          end else begin
            ch_d    = ch_q + 3'd1;
            state_d = SHIFT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin-facing outputs are registered from next-state so they never glitch.
  always_ff @(posedge CLK50) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= 3'd0;
      bit_q   <= 5'd0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      rx_q    <= '0;
      mosi_q  <= 1'b0;
      sclk_q  <= 1'b0;
      csn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      if (w_rise) rx_q <= {rx_q[ADC_BITS-2:0], SPI_IN};
      mosi_q  <= (state_d == SHIFT) ? frame_bit(bit_d, ch_d) : 1'b0;
      sclk_q  <= (state_d == SHIFT) && phase_d;
      csn_q   <= (state_d != SHIFT);
    end
  end

  always_ff @(posedge CLK50) begin
    if (reset) begin
      adc_out_q   <= '0;
      adc_valid_q <= '0;
    end else begin
      adc_valid_q <= '0;
      if (w_load) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (ch_q == 3'(i)) begin
            adc_out_q[i*ADC_BITS +: ADC_BITS] <= rx_q;
            adc_valid_q[i]                    <= 1'b1;
          end
        end
      end
    end
  end

  assign SPI_OUT   = mosi_q;
  assign SCLK      = sclk_q;
  assign CS_n      = csn_q;
  assign adc_out   = adc_out_q;
  assign adc_valid = adc_valid_q;
  assign busy      = (state_q != IDLE);
  assign scan_done = (state_q == HOLD) && (cnt_q == HOLD_LAST) && (ch_q == LAST_CH);

endmodule
`default_nettype wire

// File: tb/tb_mcp3x08_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mcp3x08_scanner: scoreboard bench with behavioural MCP3008/3208 models. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mcp3x08_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- DUT A: MCP3008, 2 channels ----------------
  logic        rst_a = 1'b1, en_a = 1'b0, trg_a = 1'b0, miso_a = 1'b0;
  logic        mosi_a, sclk_a, csn_a, busy_a, done_a;
  logic [19:0] out_a;
  logic [1:0]  valid_a;

  mcp3x08_scanner #(.ADC_BITS(10), .CHANNELS(2), .CLK_DIV(2), .CS_IDLE(4), .DIFF_MASK(8'h00)) u_a (
    .CLK50(clk), .reset(rst_a), .enable(en_a), .trigger(trg_a), .SPI_IN(miso_a),
    .SPI_OUT(mosi_a), .SCLK(sclk_a), .CS_n(csn_a), .adc_out(out_a),
    .adc_valid(valid_a), .busy(busy_a), .scan_done(done_a));

  // ---------------- DUT B: MCP3208, 8 channels ----------------
  logic        rst_b = 1'b1, en_b = 1'b0, trg_b = 1'b0, miso_b = 1'b0;
  logic        mosi_b, sclk_b, csn_b, busy_b, done_b;
  logic [95:0] out_b;
  logic [7:0]  valid_b;

  mcp3x08_scanner #(.ADC_BITS(12), .CHANNELS(8), .CLK_DIV(2), .CS_IDLE(4), .DIFF_MASK(8'h04)) u_b (
    .CLK50(clk), .reset(rst_b), .enable(en_b), .trigger(trg_b), .SPI_IN(miso_b),
    .SPI_OUT(mosi_b), .SCLK(sclk_b), .CS_n(csn_b), .adc_out(out_b),
    .adc_valid(valid_b), .busy(busy_b), .scan_done(done_b));

  logic [9:0]  mem_a [8];
  logic [11:0] mem_b [8];
  logic [23:0] qa_frm[$], qb_frm[$];
  logic [15:0] qa_res[$], qb_res[$];
  logic [23:0] frm_b_tab [8] = '{24'h060000, 24'h064000, 24'h048000, 24'h06C000,
                                 24'h070000, 24'h074000, 24'h078000, 24'h07C000};

  // ---------------- ADC model A + MOSI frame monitor ----------------
  int          k_a = 0;
  logic [23:0] mf_a = '0;
  logic        prev_sclk_a = 1'b0, prev_csn_a = 1'b1, abort_a = 1'b0;
  logic [2:0]  ch_a;
  always @(negedge clk) begin
    if (csn_a) begin
      if (!prev_csn_a) begin
        if (k_a != 24) begin
          if (!abort_a) fail("a_frame_short", 128'(k_a), 128'(24));
        end else if (qa_frm.size() == 0) fail("a_frame_unexpected", 128'(mf_a), 128'(0));
        else check("a_mosi_frame", 128'(mf_a), 128'(qa_frm.pop_front()));
      end
      k_a = 0; mf_a = '0; miso_a = 1'b0; prev_sclk_a = 1'b0;
    end else begin
      if (sclk_a && !prev_sclk_a) begin
        mf_a[23-k_a] = mosi_a;
        k_a++;
      end
      prev_sclk_a = sclk_a;
      ch_a   = {mf_a[14], mf_a[13], mf_a[12]};
      miso_a = (k_a >= 14 && k_a < 24) ? mem_a[ch_a][23-k_a] : 1'b0;
    end
    prev_csn_a = csn_a;
  end

  // ---------------- ADC model B + MOSI frame monitor ----------------
  int          k_b = 0;
  logic [23:0] mf_b = '0;
  logic        prev_sclk_b = 1'b0, prev_csn_b = 1'b1;
  logic [2:0]  ch_b;
  always @(negedge clk) begin
    if (csn_b) begin
      if (!prev_csn_b) begin
        if (k_b != 24) fail("b_frame_short", 128'(k_b), 128'(24));
        else if (qb_frm.size() == 0) fail("b_frame_unexpected", 128'(mf_b), 128'(0));
        else check("b_mosi_frame", 128'(mf_b), 128'(qb_frm.pop_front()));
      end
      k_b = 0; mf_b = '0; miso_b = 1'b0; prev_sclk_b = 1'b0;
    end else begin
      if (sclk_b && !prev_sclk_b) begin
        mf_b[23-k_b] = mosi_b;
        k_b++;
      end
      prev_sclk_b = sclk_b;
      ch_b   = {mf_b[16], mf_b[15], mf_b[14]};
      miso_b = (k_b >= 12 && k_b < 24) ? mem_b[ch_b][23-k_b] : 1'b0;
    end
    prev_csn_b = csn_b;
  end

  // ---------------- result scoreboards ----------------
  logic [19:0] exp_out_a = '0;
  logic [95:0] exp_out_b = '0;
  logic [15:0] ea, eb;
  int done_cnt_a = 0, done_cnt_b = 0;

  always @(negedge clk) begin
    if (rst_a) exp_out_a = '0;
    if (done_a) done_cnt_a++;
    if (valid_a != 2'b00) begin
      if (qa_res.size() == 0) fail("a_valid_unexpected", 128'(valid_a), 128'(0));
      else begin
        ea = qa_res.pop_front();
        exp_out_a[int'(ea[14:12])*10 +: 10] = ea[9:0];
        check("a_valid_chan", 128'(valid_a), 128'(2'b01 << ea[14:12]));
        check("a_adc_out", 128'(out_a), 128'(exp_out_a));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b) exp_out_b = '0;
    if (done_b) done_cnt_b++;
    if (valid_b != 8'h00) begin
      if (qb_res.size() == 0) fail("b_valid_unexpected", 128'(valid_b), 128'(0));
      else begin
        eb = qb_res.pop_front();
        exp_out_b[int'(eb[14:12])*12 +: 12] = eb[11:0];
        check("b_valid_chan", 128'(valid_b), 128'(8'h01 << eb[14:12]));
        check("b_adc_out", 128'(out_b), 128'(exp_out_b));
      end
    end
  end

  task automatic push_a_scan();
    qa_frm.push_back(24'h018000);
    qa_frm.push_back(24'h019000);
    qa_res.push_back({4'd0, 2'b00, mem_a[0]});
    qa_res.push_back({4'd1, 2'b00, mem_a[1]});
  endtask

  task automatic pulse_trg_a();
    trg_a = 1'b1;
    @(negedge clk);
    trg_a = 1'b0;
  endtask

  task automatic wait_idle_a(input string name);
    int t = 0;
    while (busy_a && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) fail(name, 128'(busy_a), 128'(0));
  endtask

  initial begin
    int t, t0, d0;
    mem_a = '{10'h2A5, 10'h15A, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0};
    mem_b = '{12'h001, 12'h802, 12'hFFF, 12'h000, 12'h123, 12'h456, 12'h789, 12'hABC};
    repeat (3) @(negedge clk);
    check("a_reset_ctrl", 128'({csn_a, sclk_a, mosi_a, busy_a, done_a, valid_a}), 128'(7'b1000000));
    check("a_reset_out", 128'(out_a), 128'(0));
    check("b_reset_ctrl", 128'({csn_b, sclk_b, mosi_b, busy_b, done_b, valid_b}), 128'(13'h1000));
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("a_idle_after_reset", 128'({csn_a, busy_a}), 128'(2'b10));

    // Single triggered scan: 2A5 / 15A, 101 cycles between strobes.
    push_a_scan();
    d0 = done_cnt_a;
    pulse_trg_a();
    check("a_busy_after_trigger", 128'(busy_a), 128'(1));
    t = 0;
    while (!valid_a[0] && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) fail("a_wait_valid0", 128'(valid_a), 128'(1));
    t0 = cyc;
    @(negedge clk);
    t = 0;
    while (!valid_a[1] && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) fail("a_wait_valid1", 128'(valid_a), 128'(2));
    check("a_valid_spacing", 128'(cyc - t0), 128'(101));
    wait_idle_a("a_wait_idle1");
    check("a_done_once", 128'(done_cnt_a - d0), 128'(1));
    check("a_cs_high_idle", 128'(csn_a), 128'(1));

    // Enable drops during the channel-0 frame; a trigger while busy is ignored.
    push_a_scan();
    d0 = done_cnt_a;
    en_a = 1'b1;
    t = 0;
    while (csn_a && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail("a_wait_cs_fall", 128'(csn_a), 128'(0));
    repeat (20) @(negedge clk);
    en_a = 1'b0;
    repeat (10) @(negedge clk);
    check("a_busy_mid_scan", 128'(busy_a), 128'(1));
    pulse_trg_a();
    wait_idle_a("a_wait_idle2");
    check("a_done_after_enable_drop", 128'(done_cnt_a - d0), 128'(1));
    repeat (300) @(negedge clk);
    check("a_no_extra_frame", 128'({busy_a, csn_a}), 128'(2'b01));

    // Reset at bit 12, then a clean restart from channel 0.
    pulse_trg_a();
    t = 0;
    while (k_a != 12 && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) fail("a_wait_bit12", 128'(k_a), 128'(12));
    abort_a = 1'b1;
    rst_a   = 1'b1;
    @(negedge clk);
    check("a_rst_mid_ctrl", 128'({csn_a, sclk_a, mosi_a, busy_a, done_a, valid_a}), 128'(7'b1000000));
    check("a_rst_mid_out", 128'(out_a), 128'(0));
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    abort_a  = 1'b0;
    mem_a[0] = 10'h3FF;
    mem_a[1] = 10'h001;
    push_a_scan();
    d0 = done_cnt_a;
    pulse_trg_a();
    wait_idle_a("a_wait_idle3");
    check("a_done_after_restart", 128'(done_cnt_a - d0), 128'(1));

    // Continuous scan on the 12-bit, 8-channel instance.
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 8; c++) begin
        qb_frm.push_back(frm_b_tab[c]);
        qb_res.push_back({1'b0, 3'(c), mem_b[c]});
      end
    en_b = 1'b1;
    t = 0;
    while (!done_b && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) fail("b_wait_done", 128'(done_b), 128'(1));
    t0 = cyc;
    @(negedge clk);
    t = 0;
    while (csn_b && t < 10) begin @(negedge clk); t++; end
    if (t >= 10) fail("b_wait_cs_fall", 128'(csn_b), 128'(0));
    check("b_wrap_no_idle", 128'(cyc - t0), 128'(1));
    check("b_busy_at_wrap", 128'(busy_b), 128'(1));
    check("b_ch7_result", 128'(out_b[84 +: 12]), 128'(12'hABC));
    repeat (20) @(negedge clk);
    en_b = 1'b0;
    t = 0;
    while (busy_b && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) fail("b_wait_idle", 128'(busy_b), 128'(0));
    check("b_done_count", 128'(done_cnt_b), 128'(2));

    repeat (20) @(negedge clk);
    check("a_frames_left", 128'(qa_frm.size()), 128'(0));
    check("a_results_left", 128'(qa_res.size()), 128'(0));
    check("b_frames_left", 128'(qb_frm.size()), 128'(0));
    check("b_results_left", 128'(qb_res.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
